// File: rtl/credit_game_ctrl.sv
// Coin/credit/start/attract controller for 1..4-player arcade cores.
// Latency: COIN_N low first sampled at edge t -> CREDITS updates at edge t+3; START_GAME pulses the cycle after the accepted tick.
// Backpressure: none; coins are dropped while credits are saturated, and COIN_LOCKOUT is raised then.
// Optional feature: define FREE_PLAY_EN to add the FREE_PLAY input (starts accepted without credits).
module credit_game_ctrl #(
  parameter int NUM_PLAYERS      = 2,
  parameter int CREDIT_W         = 4,
  parameter int MAX_CREDITS      = 9,
  parameter int COINS_PER_CREDIT = 1
) (
  input  logic                   CLK_DRV,
  input  logic                   RESET,
  input  logic [1:0]             COIN_N,
  input  logic [NUM_PLAYERS-1:0] START_N,
  input  logic                   FRAME_TICK,
  input  logic                   EGL,
`ifdef FREE_PLAY_EN
  input  logic                   FREE_PLAY,
`endif
  output logic [CREDIT_W-1:0]    CREDITS,
  output logic [NUM_PLAYERS-1:0] CREDIT_OK,
  output logic                   COIN_LOCKOUT,
  output logic                   START_GAME,
  output logic [1:0]             PLAYERS,
  output logic                   ATTRACT,
  output logic                   ATTRACT_N
);

  // One extra bit so that "credits - cost + gain" can exceed MAX before clamping.
  localparam int                 CW1     = CREDIT_W + 1;
  localparam logic [CW1-1:0]     MAX_EXT = CW1'(MAX_CREDITS);
  localparam logic [4:0]         CPC1    = 5'(COINS_PER_CREDIT);
  localparam logic [4:0]         CPC2    = 5'(2 * COINS_PER_CREDIT);

  typedef enum logic [1:0] {
    S_ATTRACT = 2'd0,
    S_PLAY    = 2'd1,
    S_OVER    = 2'd2
  } state_t;

  state_t                 state_q;
  state_t                 state_d;

  logic [1:0]             coin_s1;
  logic [1:0]             coin_s2;
  logic [1:0]             coin_prev;
  logic [1:0]             coin_fall;
  logic [1:0]             coin_cnt_q;
  logic [NUM_PLAYERS-1:0] start_s1;
  logic [NUM_PLAYERS-1:0] start_s2;

  logic [3:0]             acc_q;
  logic [3:0]             acc_d;
  logic [4:0]             acc_sum;
  logic [CW1-1:0]         gain;
  logic [CW1-1:0]         cost;
  logic [CW1-1:0]         credits_sum;
  logic [CREDIT_W-1:0]    credits_q;
  logic [CREDIT_W-1:0]    credits_d;

  logic                   free_play;
  logic                   saturated;
  logic [NUM_PLAYERS-1:0] credit_ok;
  logic                   cand_vld;
  logic [1:0]             cand_idx;
  logic                   start_now;

  logic [1:0]             players_q;
  logic                   start_game_q;
  logic                   attract_q;
  logic                   attract_n_q;

`ifdef FREE_PLAY_EN
  assign free_play = FREE_PLAY;
`else
  assign free_play = 1'b0;
`endif

  // Two-flop synchronisers for the asynchronous cabinet switches, plus a delayed copy of the coin lines for edge detection.
  always_ff @(posedge CLK_DRV) begin
    if (RESET) begin
      coin_s1   <= '1;
      coin_s2   <= '1;
      coin_prev <= '1;
      start_s1  <= '1;
      start_s2  <= '1;
    end else begin
      coin_s1   <= COIN_N;
      coin_s2   <= coin_s1;
      coin_prev <= coin_s2;
      start_s1  <= START_N;
      start_s2  <= start_s1;
    end
  end

  // A coin is a high-to-low transition of a synchronised coin line.
  assign coin_fall = coin_prev & ~coin_s2;

  // Register the per-cycle coin count (0..2) so credits land exactly three edges after the first low sample.
  always_ff @(posedge CLK_DRV) begin
    if (RESET) begin
      coin_cnt_q <= '0;
    end else begin
      coin_cnt_q <= {1'b0, coin_fall[0]} + {1'b0, coin_fall[1]};
    end
  end

  assign saturated = (credits_q == CREDIT_W'(MAX_CREDITS));

  // Affordability per start button; in free play every button is affordable.
  always_comb begin
    credit_ok = '0;
    for (int k = 0; k < NUM_PLAYERS; k++) begin
      credit_ok[k] = free_play || (int'(credits_q) >= (k + 1));
    end
  end

  // Game state machine: pick the largest affordable pressed start on a frame tick, run the game until EGL, then a one-cycle OVER.
  always_comb begin
    state_d   = state_q;
    cand_vld  = 1'b0;
    cand_idx  = '0;
    start_now = 1'b0;
    cost      = '0;
    // Later iterations overwrite earlier ones, so the highest qualifying index wins.
    for (int k = 0; k < NUM_PLAYERS; k++) begin
      if (!start_s2[k] && credit_ok[k]) begin
        cand_vld = 1'b1;
        cand_idx = 2'(k);
      end
    end
    case (state_q)
      S_ATTRACT: begin
        if (FRAME_TICK && cand_vld) begin
          start_now = 1'b1;
          state_d   = S_PLAY;
          if (!free_play) begin
            cost = CW1'(cand_idx) + CW1'(1);
          end
        end
      end
      S_PLAY: begin
        if (EGL) begin
          state_d = S_OVER;
        end
      end
      S_OVER: begin
        state_d = S_ATTRACT;
      end
      default: begin
        state_d = S_ATTRACT;
      end
    endcase
  end

  // Coin accumulation and credit arithmetic: deduction and coin gain combine in one step, then clamp at MAX_CREDITS.
  always_comb begin
    acc_sum = {1'b0, acc_q} + {3'b000, coin_cnt_q};
    gain    = '0;
    acc_d   = acc_q;
    if (saturated) begin
      // Coins arriving at a full credit register are swallowed and the partial count is forgotten.
      acc_d = '0;
    end else if (acc_sum >= CPC2) begin
      gain  = CW1'(2);
      acc_d = 4'(acc_sum - CPC2);
    end else if (acc_sum >= CPC1) begin
      gain  = CW1'(1);
      acc_d = 4'(acc_sum - CPC1);
    end else begin
      acc_d = acc_sum[3:0];
    end
    // cost never exceeds credits_q, so the subtraction cannot wrap.
    credits_sum = {1'b0, credits_q} - cost + gain;
    if (credits_sum > MAX_EXT) begin
      credits_d = CREDIT_W'(MAX_CREDITS);
    end else begin
      credits_d = credits_sum[CREDIT_W-1:0];
    end
  end

  // State, credit and game-status registers.
  always_ff @(posedge CLK_DRV) begin
    if (RESET) begin
      state_q      <= S_ATTRACT;
      credits_q    <= '0;
      acc_q        <= '0;
      players_q    <= '0;
      start_game_q <= 1'b0;
      attract_q    <= 1'b1;
      attract_n_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      credits_q    <= credits_d;
      acc_q        <= acc_d;
      start_game_q <= start_now;
      // Loaded from the next state so ATTRACT tracks the state register without a cycle of lag.
      attract_q    <= (state_d == S_ATTRACT);
      attract_n_q  <= (state_d != S_ATTRACT);
      // PLAYERS holds the last game's count until the next start.
      if (start_now) begin
        players_q <= cand_idx;
      end
    end
  end

  assign CREDITS      = credits_q;
  assign CREDIT_OK    = credit_ok;
  assign COIN_LOCKOUT = saturated;
  assign START_GAME   = start_game_q;
  assign PLAYERS      = players_q;
  assign ATTRACT      = attract_q;
  assign ATTRACT_N    = attract_n_q;

endmodule

// File: tb/tb_credit_game_ctrl.sv
// Directed bench for credit_game_ctrl: default build on dut, COINS_PER_CREDIT=2 on dut_b.
// Inputs are driven and outputs sampled on the falling clock edge.
// Free-play checks are compiled in when FREE_PLAY_EN is defined.
module tb_credit_game_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic [1:0] coin_n;
  logic [1:0] start_n;
  logic       frame_tick;
  logic       egl;
  logic       free_play;
  logic [3:0] credits;
  logic [1:0] credit_ok;
  logic       coin_lockout;
  logic       start_game;
  logic [1:0] players;
  logic       attract;
  logic       attract_n;

  logic [1:0] coin_n_b;
  logic [1:0] start_n_b;
  logic       tick_b;
  logic       egl_b;
  logic       free_play_b;
  logic [3:0] credits_b;
  logic [1:0] credit_ok_b;
  logic       coin_lockout_b;
  logic       start_game_b;
  logic [1:0] players_b;
  logic       attract_b;
  logic       attract_n_b;

  int   n_vec = 0;
  int   n_bad = 0;
  logic sg_seen;

  always #5 clk = ~clk;

  credit_game_ctrl dut (
    .CLK_DRV      (clk),
    .RESET        (reset),
    .COIN_N       (coin_n),
    .START_N      (start_n),
    .FRAME_TICK   (frame_tick),
    .EGL          (egl),
`ifdef FREE_PLAY_EN
    .FREE_PLAY    (free_play),
`endif
    .CREDITS      (credits),
    .CREDIT_OK    (credit_ok),
    .COIN_LOCKOUT (coin_lockout),
    .START_GAME   (start_game),
    .PLAYERS      (players),
    .ATTRACT      (attract),
    .ATTRACT_N    (attract_n)
  );

  credit_game_ctrl #(.COINS_PER_CREDIT(2)) dut_b (
    .CLK_DRV      (clk),
    .RESET        (reset),
    .COIN_N       (coin_n_b),
    .START_N      (start_n_b),
    .FRAME_TICK   (tick_b),
    .EGL          (egl_b),
`ifdef FREE_PLAY_EN
    .FREE_PLAY    (free_play_b),
`endif
    .CREDITS      (credits_b),
    .CREDIT_OK    (credit_ok_b),
    .COIN_LOCKOUT (coin_lockout_b),
    .START_GAME   (start_game_b),
    .PLAYERS      (players_b),
    .ATTRACT      (attract_b),
    .ATTRACT_N    (attract_n_b)
  );

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, want %0d", tag, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic coin_pulse(input int idx);
    coin_n[idx] = 1'b0;
    step(2);
    coin_n[idx] = 1'b1;
    step(2);
  endtask

  task automatic coin_pulse_b(input int idx);
    coin_n_b[idx] = 1'b0;
    step(2);
    coin_n_b[idx] = 1'b1;
    step(2);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset       = 1'b1;
    coin_n      = 2'b11;
    start_n     = 2'b11;
    frame_tick  = 1'b0;
    egl         = 1'b0;
    free_play   = 1'b0;
    coin_n_b    = 2'b11;
    start_n_b   = 2'b11;
    tick_b      = 1'b0;
    egl_b       = 1'b0;
    free_play_b = 1'b0;
    step(3);
    reset = 1'b0;

    chk("rst_credits",  credits,      0);
    chk("rst_attract",  attract,      1);
    chk("rst_attract_n", attract_n,   0);
    chk("rst_start",    start_game,   0);
    chk("rst_players",  players,      0);
    chk("rst_lockout",  coin_lockout, 0);
    chk("rst_credit_ok", credit_ok,   0);

    // Idle 20 cycles with occasional ticks and no buttons.
    sg_seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      frame_tick = (i % 5 == 0);
      step(1);
      sg_seen = sg_seen | start_game;
    end
    frame_tick = 1'b0;
    chk("idle_credits", credits, 0);
    chk("idle_attract", attract, 1);
    chk("idle_no_start", sg_seen, 0);

    // COINS_PER_CREDIT=2 instance: 1 pulse -> 0, 3 pulses -> 1, 4 pulses -> 2.
    coin_pulse_b(1);
    step(4);
    chk("cpc2_after1", credits_b, 0);
    coin_pulse_b(1);
    coin_pulse_b(1);
    step(4);
    chk("cpc2_after3", credits_b, 1);
    coin_pulse_b(1);
    step(4);
    chk("cpc2_after4", credits_b, 2);

    // One long coin press: credit appears exactly three edges after the first low sample.
    coin_n = 2'b10;
    step(3);
    chk("coin_t+2", credits, 0);
    step(1);
    chk("coin_t+3", credits, 1);
    step(6);
    coin_n = 2'b11;
    step(10);
    chk("coin_once", credits, 1);
    chk("coin_ok", credit_ok, 2'b01);

    // Both starts pressed with one credit: 2P unaffordable, 1P taken.
    start_n = 2'b00;
    step(3);
    frame_tick = 1'b1;
    step(1);
    frame_tick = 1'b0;
    chk("s1_pulse",   start_game, 1);
    chk("s1_credits", credits,    0);
    chk("s1_players", players,    0);
    chk("s1_attract", attract,    0);
    chk("s1_attr_n",  attract_n,  1);
    step(1);
    chk("s1_pulse_end", start_game, 0);
    start_n = 2'b11;

    // End of game: one OVER cycle, then back to ATTRACT.
    egl = 1'b1;
    step(1);
    egl = 1'b0;
    chk("over_attract", attract, 0);
    step(1);
    chk("back_attract", attract,   1);
    chk("back_attr_n",  attract_n, 0);

    // Three credits, 2P held for 50 cycles with no tick, then a tick.
    coin_pulse(0);
    coin_pulse(0);
    coin_pulse(0);
    step(4);
    chk("three_credits", credits, 3);
    start_n = 2'b01;
    sg_seen = 1'b0;
    for (int i = 0; i < 50; i++) begin
      step(1);
      sg_seen = sg_seen | start_game;
    end
    chk("notick_start",   sg_seen, 0);
    chk("notick_credits", credits, 3);
    frame_tick = 1'b1;
    step(1);
    frame_tick = 1'b0;
    chk("s2_pulse",   start_game, 1);
    chk("s2_credits", credits,    1);
    chk("s2_players", players,    1);

    // Starts are ignored during PLAY.
    frame_tick = 1'b1;
    step(1);
    frame_tick = 1'b0;
    chk("play_no_start", start_game, 0);
    chk("play_credits",  credits,    1);
    start_n = 2'b11;
    egl = 1'b1;
    step(1);
    egl = 1'b0;
    step(1);
    chk("end2_attract", attract, 1);
    chk("players_hold", players, 1);

    // Both coin lines fall together: two coins.
    coin_n = 2'b00;
    step(2);
    coin_n = 2'b11;
    step(4);
    chk("dual_coin", credits, 3);

    // Twelve more coins saturate at 9.
    for (int i = 0; i < 12; i++) coin_pulse(0);
    step(4);
    chk("sat_credits", credits,      9);
    chk("sat_lockout", coin_lockout, 1);
    chk("sat_ok",      credit_ok,    2'b11);

    // 1P start at saturation, coin lands the same edge: coin discarded, 9-1 = 8.
    start_n = 2'b10;
    step(3);
    coin_n = 2'b10;
    step(3);
    frame_tick = 1'b1;
    step(1);
    frame_tick = 1'b0;
    coin_n = 2'b11;
    chk("satdeduct_credits", credits,      8);
    chk("satdeduct_pulse",   start_game,   1);
    chk("satdeduct_players", players,      0);
    chk("satdeduct_lockout", coin_lockout, 0);
    egl = 1'b1;
    step(1);
    egl = 1'b0;
    step(1);

    // 2P start with a coin landing the same edge: 8-2+1 = 7.
    start_n = 2'b01;
    step(3);
    coin_n = 2'b10;
    step(3);
    frame_tick = 1'b1;
    step(1);
    frame_tick = 1'b0;
    coin_n = 2'b11;
    chk("mix_credits", credits,    7);
    chk("mix_pulse",   start_game, 1);
    chk("mix_players", players,    1);

    // Reset in the middle of a game.
    step(2);
    reset = 1'b1;
    step(1);
    chk("midrst_credits", credits,   0);
    chk("midrst_attract", attract,   1);
    chk("midrst_attr_n",  attract_n, 0);
    chk("midrst_players", players,   0);
    reset = 1'b0;

    // 2P still held with no credits: tick does nothing.
    step(3);
    frame_tick = 1'b1;
    step(1);
    frame_tick = 1'b0;
    chk("broke_no_start", start_game, 0);
    chk("broke_attract",  attract,    1);

`ifdef FREE_PLAY_EN
    // Free play: start accepted with zero credits, nothing deducted.
    free_play = 1'b1;
    step(1);
    chk("fp_ok", credit_ok, 2'b11);
    frame_tick = 1'b1;
    step(1);
    frame_tick = 1'b0;
    chk("fp_pulse",   start_game, 1);
    chk("fp_credits", credits,    0);
    chk("fp_players", players,    1);
    chk("fp_attract", attract,    0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
